inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
Upstream feeder of topcontrol's instruction port. On a start command it fetches a packed instruction program from DDR through one muxddr-style request/FIFO client port and unpacks each 512-bit DDR word into 160-bit instructions. It buffers the instructions in an internal show-ahead FIFO and presents them on instruct / inst_empty / inst_req.

Parameters:
INST_LEN, 160, instruction width; INST_PER_WORD = DDR_DATA_LEN/INST_LEN, which is 3 at defaults
DDR_DATA_LEN, 512, DDR FIFO word width
DDR_ADDR_LEN, 32, DDR address width
SINGLE_LEN, 24, width of the length and count fields
FIFO_AW, 4, log2 of the instruction FIFO depth (16 entries)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse that launches a program fetch
prog_ddr_addr  in  DDR_ADDR_LEN  DDR start address of the program, sampled on start
prog_inst_num  in  SINGLE_LEN  number of instructions, sampled on start
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the last instruction is pushed into the FIFO
ddr_st_addr_out  out  DDR_ADDR_LEN  read start address sent to the DDR client
ddr_len  out  SINGLE_LEN  read length in DDR words
ddr_conf  out  1  one-cycle request pulse to the DDR client
ddr_fifo_empty  in  1  DDR read FIFO is empty
ddr_fifo_req  out  1  DDR read FIFO pop; data arrives 1 cycle later
ddr_fifo_data  in  DDR_DATA_LEN  DDR read FIFO data
instruct  out  INST_LEN  head of the instruction FIFO; valid while inst_empty=0
inst_empty  out  1  instruction FIFO is empty
inst_req  in  1  pop of the instruction FIFO head

Behaviour:
- Clock and reset: clk is the single clock. rst_n is asynchronous and active-low.
- Reset values: busy=0, done=0, ddr_conf=0, ddr_fifo_req=0, ddr_st_addr_out=0, ddr_len=0, instruct=0, inst_empty=1. Reset also flushes the FIFO, clears all counters and returns the FSM to IDLE. A reset in the middle of a fetch abandons the fetch; no done pulse is produced.
- FSM states: IDLE, CONF, WAIT, LOAD, UNPACK, FIN.
- IDLE: a start pulse latches the address and count.
  - If count = 0, go to FIN (done is pulsed the next cycle).
  - Otherwise go to CONF.
  - start is ignored in every state except IDLE.
- CONF: for one cycle drive ddr_conf=1, ddr_st_addr_out = latched address, ddr_len = ceil(count/3). ddr_st_addr_out and ddr_len hold their values until the next CONF. Go to WAIT.
- WAIT: when ddr_fifo_empty=0, assert ddr_fifo_req=1 for one cycle, then go to LOAD. Never pop while ddr_fifo_empty=1.
- LOAD: capture ddr_fifo_data into the word register. Set slot=0 and slots_valid = min(3, remaining). Go to UNPACK.
- UNPACK: each cycle the FIFO is not full, push word[slot*160 +: 160] and increment slot.
  - Word bits 511:480 are ignored.
  - When slot reaches slots_valid: go to FIN if remaining = 0, else go to WAIT.
  - The last word may be partial; only the remaining instructions in it are pushed.
  - While the FIFO is full, UNPACK stalls with no loss and no duplication of instructions.
- FIN: done=1 for one cycle, busy drops in the same cycle, go to IDLE. done means all instructions are pushed; it does not mean they are consumed.
- FIFO: depth 2^FIFO_AW, show-ahead, with instruct taken from the head register. inst_empty is registered.
  - A push is accepted only when count < depth.
  - A pop is accepted only when count > 0. inst_req while inst_empty=1 is ignored.
  - Simultaneous push and pop: count is unchanged. When the FIFO holds 1 entry, the head advances to the pushed word in the next cycle.
  - Read and write pointers wrap modulo the depth.
- Ordering: instructions come out in DDR order, word by word, slot 0 before slot 1 before slot 2.
- Instructions left in the FIFO persist after done. A new program's instructions are appended behind them.

Test Plan:
- Reset with the FIFO loaded -> after rst_n rises, inst_empty=1, busy=0 and the FSM is in IDLE; a following start fetches normally.
- start with addr=0x1000, num=7; DDR words W0..W2 supplied -> one ddr_conf pulse with ddr_len=3 and addr 0x1000, exactly 3 ddr_fifo_req pulses. Output order is W0[159:0], W0[319:160], W0[479:320], W1[159:0], W1[319:160], W1[479:320], W2[159:0]. done pulses once; busy is low afterwards.
- num=20 with inst_req held 0 -> the FIFO fills to 16 and UNPACK stalls. Releasing inst_req delivers all 20 instructions in order with no duplicates.
- inst_req pulses while inst_empty=1, and a simultaneous push and pop at a count of 1 and at a count of 16 -> the count stays correct in each case.
- num=0 -> no ddr_conf and done one cycle after start. A second start pulsed while busy -> ignored; only one ddr_conf pulse is issued.
- rst_n asserted in the middle of UNPACK -> the FIFO is flushed and there is no done pulse.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - DDR program fetcher that unpacks 512-bit words into a 160-bit instruction FIFO
// Each fetched DDR word carries INST_PER_WORD instructions; the unused top bits of the word are dropped.
module inst_fetch_unit #(
    parameter int INST_LEN     = 160,
    parameter int DDR_DATA_LEN = 512,
    parameter int DDR_ADDR_LEN = 32,
    parameter int SINGLE_LEN   = 24,
    parameter int FIFO_AW      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DDR_ADDR_LEN-1:0] prog_ddr_addr,
    input  logic [SINGLE_LEN-1:0]   prog_inst_num,
    output logic                    busy,
    output logic                    done,
    output logic [DDR_ADDR_LEN-1:0] ddr_st_addr_out,
    output logic [SINGLE_LEN-1:0]   ddr_len,
    output logic                    ddr_conf,
    input  logic                    ddr_fifo_empty,
    output logic                    ddr_fifo_req,
    input  logic [DDR_DATA_LEN-1:0] ddr_fifo_data,
    output logic [INST_LEN-1:0]     instruct,
    output logic                    inst_empty,
    input  logic                    inst_req
);
    localparam int INST_PER_WORD = DDR_DATA_LEN / INST_LEN;
    localparam int SLOT_W        = $clog2(INST_PER_WORD + 1);
    localparam int NUM_SLOTS     = 2 ** SLOT_W;
    localparam int EXT_LEN       = NUM_SLOTS * INST_LEN;
    localparam int DEPTH         = 2 ** FIFO_AW;

    localparam logic [SINGLE_LEN-1:0] IPW_CNT   = SINGLE_LEN'(INST_PER_WORD);
    localparam logic [SINGLE_LEN:0]   IPW_WIDE  = (SINGLE_LEN+1)'(INST_PER_WORD);
    localparam logic [SINGLE_LEN:0]   IPW_ROUND = (SINGLE_LEN+1)'(INST_PER_WORD - 1);
    localparam logic [SLOT_W-1:0]     IPW_SLOT  = SLOT_W'(INST_PER_WORD);
    localparam logic [FIFO_AW:0]      DEPTH_CNT = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0]      CNT_ONE   = (FIFO_AW+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONF,
        S_WAIT,
        S_LOAD,
        S_UNPACK,
        S_FIN
    } state_t;

    state_t                   state_q, state_d;
    logic [SINGLE_LEN-1:0]    remaining_q, remaining_d;
    logic [DDR_DATA_LEN-1:0]  word_q, word_d;
    logic [SLOT_W-1:0]        slot_q, slot_d;
    logic [SLOT_W-1:0]        slots_valid_q, slots_valid_d;
    logic [DDR_ADDR_LEN-1:0]  st_addr_q, st_addr_d;
    logic [SINGLE_LEN-1:0]    len_q, len_d;

    logic [SINGLE_LEN:0]      num_round;
    logic [SINGLE_LEN-1:0]    len_calc;
    logic [EXT_LEN-1:0]       word_ext;
    logic [INST_LEN-1:0]      slot_data [NUM_SLOTS];
    logic [INST_LEN-1:0]      push_data;
    logic                     push;

    logic [INST_LEN-1:0]      mem_q [DEPTH];
    logic [FIFO_AW-1:0]       wr_ptr_q, rd_ptr_q, rd_next;
    logic [FIFO_AW:0]         cnt_q, cnt_d;
    logic [INST_LEN-1:0]      head_q, head_d;
    logic                     empty_q;
    logic                     fifo_full, push_ok, pop_ok;

    // Word count rounds up so a partial last word is still fetched.
    assign num_round = {1'b0, prog_inst_num} + IPW_ROUND;
    assign len_calc  = SINGLE_LEN'(num_round / IPW_WIDE);

    always_comb begin
        word_ext = '0;
        word_ext[DDR_DATA_LEN-1:0] = word_q;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_data[i] = word_ext[i*INST_LEN +: INST_LEN];
        end
    end

    assign push_data = slot_data[slot_q];

    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        word_d        = word_q;
        slot_d        = slot_q;
        slots_valid_d = slots_valid_q;
        st_addr_d     = st_addr_q;
        len_d         = len_q;
        busy          = 1'b0;
        done          = 1'b0;
        ddr_conf      = 1'b0;
        ddr_fifo_req  = 1'b0;
        push          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    remaining_d = prog_inst_num;
                    if (prog_inst_num == '0) begin
                        state_d = S_FIN;
                    end else begin
                        st_addr_d = prog_ddr_addr;
                        len_d     = len_calc;
                        state_d   = S_CONF;
                    end
                end
            end
            S_CONF: begin
                busy     = 1'b1;
                ddr_conf = 1'b1;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (!ddr_fifo_empty) begin
                    ddr_fifo_req = 1'b1;
                    state_d      = S_LOAD;
                end
            end
            S_LOAD: begin
                busy          = 1'b1;
                word_d        = ddr_fifo_data;
                slot_d        = '0;
                slots_valid_d = (remaining_q < IPW_CNT) ? remaining_q[SLOT_W-1:0] : IPW_SLOT;
                state_d       = S_UNPACK;
            end
            S_UNPACK: begin
                busy = 1'b1;
                if (!fifo_full) begin
                    push        = 1'b1;
                    slot_d      = slot_q + SLOT_W'(1);
                    remaining_d = remaining_q - SINGLE_LEN'(1);
                    if (slot_d == slots_valid_q) begin
                        state_d = (remaining_d == '0) ? S_FIN : S_WAIT;
                    end
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            remaining_q   <= '0;
            word_q        <= '0;
            slot_q        <= '0;
            slots_valid_q <= '0;
            st_addr_q     <= '0;
            len_q         <= '0;
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            word_q        <= word_d;
            slot_q        <= slot_d;
            slots_valid_q <= slots_valid_d;
            st_addr_q     <= st_addr_d;
            len_q         <= len_d;
        end
    end

    assign ddr_st_addr_out = st_addr_q;
    assign ddr_len         = len_q;

    assign fifo_full = (cnt_q == DEPTH_CNT);
    assign push_ok   = push && !fifo_full;
    assign pop_ok    = inst_req && (cnt_q != '0);
    assign rd_next   = rd_ptr_q + FIFO_AW'(1);

    // The head register is refilled from storage, or straight from the push when the FIFO is about to hold only it.
    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (!push_ok && pop_ok) begin
            cnt_d = cnt_q - CNT_ONE;
        end
        if (pop_ok) begin
            if (cnt_q > CNT_ONE) begin
                head_d = mem_q[rd_next];
            end else if (push_ok) begin
                head_d = push_data;
            end
        end else if ((cnt_q == '0) && push_ok) begin
            head_d = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            head_q   <= '0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_next;
            end
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            empty_q <= (cnt_d == '0);
        end
    end

    assign instruct   = head_q;
    assign inst_empty = empty_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - randomized self-checking bench for inst_fetch_unit
// A DDR word store and an expected-instruction queue stand in for the program and its unpacked order.
module tb_inst_fetch_unit;
    localparam int IL = 160;
    localparam int DL = 512;
    localparam int AL = 32;
    localparam int SL = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AL-1:0] prog_ddr_addr = '0;
    logic [SL-1:0] prog_inst_num = '0;
    logic          busy, done, ddr_conf, ddr_fifo_req, inst_empty;
    logic [AL-1:0] ddr_st_addr_out;
    logic [SL-1:0] ddr_len;
    logic          ddr_fifo_empty = 1'b1;
    logic [DL-1:0] ddr_fifo_data = '0;
    logic [IL-1:0] instruct;
    logic          inst_req = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic [DL-1:0] ddr_mem [logic [AL-1:0]];
    logic [DL-1:0] ddr_q [$];
    logic [IL-1:0] exp_q [$];
    int            conf_cnt = 0;
    int            req_cnt = 0;
    int            done_cnt = 0;
    logic [AL-1:0] conf_addr = '0;
    logic [SL-1:0] conf_len = '0;
    bit            pend = 1'b0;
    bit            cons_en = 1'b0;
    int            cons_pct = 50;

    inst_fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .prog_ddr_addr   (prog_ddr_addr),
        .prog_inst_num   (prog_inst_num),
        .busy            (busy),
        .done            (done),
        .ddr_st_addr_out (ddr_st_addr_out),
        .ddr_len         (ddr_len),
        .ddr_conf        (ddr_conf),
        .ddr_fifo_empty  (ddr_fifo_empty),
        .ddr_fifo_req    (ddr_fifo_req),
        .ddr_fifo_data   (ddr_fifo_data),
        .instruct        (instruct),
        .inst_empty      (inst_empty),
        .inst_req        (inst_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [IL-1:0] got, input logic [IL-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    function automatic logic [DL-1:0] rand_word();
        logic [DL-1:0] w;
        for (int i = 0; i < DL / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // DDR client, instruction consumer and event counters, all acting on the falling edge.
    initial begin
        logic [IL-1:0] head;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0;
                inst_req = 1'b0;
                ddr_fifo_empty = 1'b1;
                ddr_q.delete();
            end else begin
                if (pend) begin
                    pend = 1'b0;
                    if (ddr_q.size() == 0) check("ddr_underrun", 1, 0);
                    else ddr_fifo_data = ddr_q.pop_front();
                end
                if (ddr_conf) begin
                    conf_cnt++;
                    conf_addr = ddr_st_addr_out;
                    conf_len = ddr_len;
                    for (int i = 0; i < int'(ddr_len); i++)
                        ddr_q.push_back(ddr_mem[ddr_st_addr_out + AL'(i)]);
                end
                if (done) done_cnt++;
                ddr_fifo_empty = (ddr_q.size() == 0) || ($urandom_range(0, 3) == 0);
                inst_req = cons_en && ($urandom_range(1, 100) <= cons_pct);
                if (inst_req && !inst_empty) begin
                    if (exp_q.size() == 0) begin
                        check("extra_inst", 1, 0);
                    end else begin
                        head = exp_q.pop_front();
                        check("inst_order", instruct, head);
                    end
                end
                #1;
                if (ddr_fifo_req) begin
                    req_cnt++;
                    check("req_only_nonempty", ddr_fifo_empty, 0);
                    pend = 1'b1;
                end
            end
        end
    end

    task automatic start_prog(input logic [AL-1:0] addr, input int num);
        int nw;
        logic [DL-1:0] wd;
        nw = (num + 2) / 3;
        for (int w = 0; w < nw; w++) ddr_mem[addr + AL'(w)] = rand_word();
        for (int k = 0; k < num; k++) begin
            wd = ddr_mem[addr + AL'(k / 3)];
            exp_q.push_back(wd[(k % 3) * IL +: IL]);
        end
        @(negedge clk);
        start = 1'b1;
        prog_ddr_addr = addr;
        prog_inst_num = SL'(num);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, num != 0);
    endtask

    task automatic wait_done(input int d0, input int budget);
        int t;
        t = 0;
        while (done_cnt == d0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", done_cnt - d0, 1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        cons_en = 1'b1;
        cons_pct = 70;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("drain_complete", exp_q.size(), 0);
        @(negedge clk);
        @(negedge clk);
        check("empty_after_drain", inst_empty, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1 check("rst_async_empty", inst_empty, 1);
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_instruct", instruct, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int d0, c0, r0, num, t;
        logic [AL-1:0] addr;

        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_conf", ddr_conf, 0);
        check("reset_req", ddr_fifo_req, 0);
        check("reset_addr", ddr_st_addr_out, 0);
        check("reset_len", ddr_len, 0);
        check("reset_instruct", instruct, 0);
        check("reset_empty", inst_empty, 1);
        #2 rst_n = 1'b1;

        // seven instructions over three words, the last one partial
        cons_en = 1'b1;
        cons_pct = 60;
        d0 = done_cnt; c0 = conf_cnt; r0 = req_cnt;
        start_prog(32'h1000, 7);
        wait_done(d0, 500);
        check("p7_conf_cnt", conf_cnt - c0, 1);
        check("p7_conf_addr", conf_addr, 32'h1000);
        check("p7_conf_len", conf_len, 3);
        check("p7_req_cnt", req_cnt - r0, 3);
        drain();
        check("p7_done_once", done_cnt - d0, 1);
        check("p7_busy_low", busy, 0);

        // twenty instructions with no consumer: FIFO fills and unpacking stalls
        cons_en = 1'b0;
        d0 = done_cnt; r0 = req_cnt;
        start_prog(32'h2000, 20);
        repeat (200) @(negedge clk);
        check("fill_busy", busy, 1);
        check("fill_no_done", done_cnt - d0, 0);
        check("fill_req_cnt", req_cnt - r0, 6);
        check("fill_not_empty", inst_empty, 0);
        cons_en = 1'b1;
        cons_pct = 100;
        wait_done(d0, 2000);
        drain();
        check("fill_req_total", req_cnt - r0, 7);

        // empty program: no DDR request, done on the following cycle
        d0 = done_cnt; c0 = conf_cnt;
        start_prog(32'h3000, 0);
        check("zero_done_next", done, 1);
        repeat (5) @(negedge clk);
        check("zero_no_conf", conf_cnt - c0, 0);
        check("zero_done_once", done_cnt - d0, 1);

        // a start while busy is ignored
        d0 = done_cnt; c0 = conf_cnt;
        start_prog(32'h4000, 6);
        repeat (3) @(negedge clk);
        start = 1'b1;
        prog_ddr_addr = 32'h5000;
        prog_inst_num = SL'(9);
        @(negedge clk);
        start = 1'b0;
        wait_done(d0, 1000);
        repeat (5) @(negedge clk);
        check("busy_start_conf_cnt", conf_cnt - c0, 1);
        check("busy_start_addr", conf_addr, 32'h4000);
        check("busy_start_len", conf_len, 2);
        check("busy_start_done_cnt", done_cnt - d0, 1);
        drain();

        // leftover instructions persist and a new program is appended behind them
        cons_en = 1'b0;
        d0 = done_cnt;
        start_prog(32'h6000, 4);
        wait_done(d0, 500);
        d0 = done_cnt;
        start_prog(32'h6100, 5);
        wait_done(d0, 500);
        check("append_not_empty", inst_empty, 0);
        drain();

        // reset with a loaded FIFO, then a normal fetch
        cons_en = 1'b0;
        d0 = done_cnt;
        start_prog(32'h7000, 5);
        wait_done(d0, 500);
        check("loaded_before_rst", inst_empty, 0);
        do_reset();
        repeat (2) @(negedge clk);
        check("after_rst_empty", inst_empty, 1);
        cons_en = 1'b1;
        cons_pct = 50;
        d0 = done_cnt; c0 = conf_cnt;
        start_prog(32'h7100, 8);
        wait_done(d0, 1000);
        check("post_rst_conf_len", conf_len, 3);
        check("post_rst_conf_cnt", conf_cnt - c0, 1);
        drain();

        // reset in the middle of unpacking abandons the fetch
        cons_en = 1'b0;
        d0 = done_cnt;
        start_prog(32'h8000, 9);
        t = 0;
        while (inst_empty && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("mid_first_push", inst_empty, 0);
        do_reset();
        repeat (30) @(negedge clk);
        check("mid_no_done", done_cnt - d0, 0);
        check("mid_flushed", inst_empty, 1);
        check("mid_idle", busy, 0);

        // random programs against the expected-order model
        for (int p = 0; p < 8; p++) begin
            num = $urandom_range(1, 40);
            addr = $urandom;
            cons_en = 1'b1;
            cons_pct = $urandom_range(10, 100);
            d0 = done_cnt; c0 = conf_cnt; r0 = req_cnt;
            start_prog(addr, num);
            wait_done(d0, 4000);
            check("rand_conf_cnt", conf_cnt - c0, 1);
            check("rand_conf_addr", conf_addr, addr);
            check("rand_conf_len", conf_len, (num + 2) / 3);
            check("rand_req_cnt", req_cnt - r0, (num + 2) / 3);
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
